// File: rtl/ap_mult_rr_sched.sv
// ============================================================================
// Module   : ap_mult_rr_sched (+ ap_si_wall_8b_r5)
// Brief    : Round-robin scheduler sharing one approximate signed 8x8 multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

// Signed Baugh-Wooley partial products with columns 0..4 removed, reduced
// by a row-level carry-save (Wallace) tree and a final carry-propagate add.
module ap_si_wall_8b_r5 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  localparam int c_drop_cols = 5;

  logic [8:0][15:0] w_pp;
  logic [15:0] w_l1s0, w_l1c0, w_l1s1, w_l1c1, w_l1s2, w_l1c2;
  logic [15:0] w_l2s0, w_l2c0, w_l2s1, w_l2c1;
  logic [15:0] w_l3s0, w_l3c0;
  logic [15:0] w_l4s0, w_l4c0;

  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i + j >= c_drop_cols) begin
          // sign-row and sign-column terms are complemented, but not their crossing
          w_pp[i][i+j] = (a[j] & b[i]) ^ ((i == 7) != (j == 7));
        end
      end
    end
    w_pp[8] = 16'h8100;
  end

  assign {w_l1c0, w_l1s0} = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_l1c1, w_l1s1} = csa(w_pp[3], w_pp[4], w_pp[5]);
  assign {w_l1c2, w_l1s2} = csa(w_pp[6], w_pp[7], w_pp[8]);
  assign {w_l2c0, w_l2s0} = csa(w_l1s0, w_l1c0, w_l1s1);
  assign {w_l2c1, w_l2s1} = csa(w_l1c1, w_l1s2, w_l1c2);
  assign {w_l3c0, w_l3s0} = csa(w_l2s0, w_l2c0, w_l2s1);
  assign {w_l4c0, w_l4s0} = csa(w_l3s0, w_l3c0, w_l2c1);
  assign p = w_l4s0 + w_l4c0;
endmodule

module ap_mult_rr_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_muld,
  input  logic [NREQ*DW-1:0] req_mulr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*DW-1:0]    rsp_res
);
  logic            r_s1_vld;
  logic [DW-1:0]   r_s1_a;
  logic [DW-1:0]   r_s1_b;
  logic [IDW-1:0]  r_s1_id;
  logic [IDW-1:0]  r_rr_ptr;

  logic            w_s2_adv;
  logic            w_s1_free;
  logic            w_found;
  logic            w_accept;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_nxt_ptr;
  logic [IDW:0]    w_ptr_inc;
  logic [2*DW-1:0] w_prod;

  assign w_s2_adv  = r_s1_vld & (~rsp_valid | rsp_ready);
  assign w_s1_free = ~r_s1_vld | w_s2_adv;

  // First requesting index at or after the pointer, wrapping at NREQ-1
  always_comb begin : p_arb
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_sum >= (IDW+1)'(NREQ)) v_sum = v_sum - (IDW+1)'(NREQ);
      v_idx = v_sum[IDW-1:0];
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_accept  = w_found & w_s1_free & ~rst;
  assign req_ready = w_accept ? (NREQ'(1) << w_win) : '0;

  assign w_ptr_inc = {1'b0, w_win} + (IDW+1)'(1);
  assign w_nxt_ptr = (w_ptr_inc >= (IDW+1)'(NREQ)) ? '0 : w_ptr_inc[IDW-1:0];

  ap_si_wall_8b_r5 u_mult (
    .a (r_s1_a),
    .b (r_s1_b),
    .p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_id   <= '0;
      r_rr_ptr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
    end else begin
      if (w_s2_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_s1_id;
        rsp_res   <= w_prod;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (w_accept) begin
        r_s1_vld <= 1'b1;
        r_s1_a   <= req_muld[w_win*DW +: DW];
        r_s1_b   <= req_mulr[w_win*DW +: DW];
        r_s1_id  <= w_win;
        r_rr_ptr <= w_nxt_ptr;
      end else if (w_s2_adv) begin
        r_s1_vld <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: doc/ap_mult_rr_sched.md
Name: ap_mult_rr_sched

Overview:
- Shares one signed approximate 8x8 Wallace multiplier instance (ap_si_wall_8b_r5) among NREQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester and on the response side.
- Two-stage registered wrapper: operand register, then combinational multiplier, then result register.
- Each response is tagged with the originating requester index. Sits between requesting compute units and the shared approximate multiplier.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand width; fixed at 8 to match ap_si_wall_8b_r5
IDW, 2, requester index width, = clog2(NREQ)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_muld  input  NREQ*DW  packed signed multiplicands; requester i at [i*DW +: DW]
req_mulr  input  NREQ*DW  packed signed multipliers; same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accept
rsp_id  output  IDW  index of the requester that owns rsp_res
rsp_res  output  2*DW  signed product from the shared multiplier

Behaviour:
- Reset: s1_vld=0, rsp_valid=0, rsp_id=0, rsp_res=0, s1 operand/id regs=0, rr_ptr=0. Reset applied mid-operation discards all in-flight work. req_ready=0 during the reset cycle.
- Stage advance:
  - s2_adv = s1_vld & (~rsp_valid | rsp_ready).
  - s1_free = ~s1_vld | s2_adv.
- Arbitration (combinational):
  - Scan req_valid starting at index rr_ptr, wrapping NREQ-1 -> 0. The first set bit is the winner.
  - req_ready[winner] = s1_free. All other req_ready bits = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept (handshake when req_valid[w] & req_ready[w]):
  - s1_a <= muld[w], s1_b <= mulr[w], s1_id <= w, s1_vld <= 1.
  - rr_ptr <= (w+1) mod NREQ.
  - No accept while s1_free: s1_vld <= 0 if s2_adv, else hold.
- rr_ptr changes only on accept. An idle cycle does not move it.
- On s2_adv: rsp_res <= product(s1_a, s1_b), rsp_id <= s1_id, rsp_valid <= 1.
- rsp_valid & rsp_ready without s2_adv: rsp_valid <= 0.
- Backpressure:
  - While rsp_valid & ~rsp_ready, rsp_res and rsp_id stay stable.
  - s1 holds its operands. Once both stages are full, all req_ready bits = 0.
- Latency and throughput:
  - Accept in cycle N -> rsp_valid high in cycle N+2, given rsp_ready.
  - Sustained throughput 1 result/cycle with rsp_ready tied high.
- Ordering: responses leave in accept order. No reordering, no drops, no duplicates.
- Arithmetic:
  - Product is exactly the ap_si_wall_8b_r5 output for (s1_a, s1_b), two's complement, 16 bits.
  - The scheduler adds no rounding or correction.
- Simultaneous events:
  - Accept and s2_adv in the same cycle is legal; s1 is overwritten with the new operands.
  - rsp_ready asserted with rsp_valid=0 has no effect.
- Pointer wrap: a winner at NREQ-1 sets rr_ptr=0.

Test Plan:
- Single request: rsp_ready=1, req_valid=4'b0100, muld=3, mulr=-5 -> req_ready=4'b0100 that cycle; rsp_valid=1 exactly 2 cycles later; rsp_id=2; rsp_res equals a standalone ap_si_wall_8b_r5 fed (3,-5). Also muld=0, mulr=-128 -> rsp_res=0.
- Fairness: all four req_valid held high for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order, 2 cycles delayed; one response per cycle.
- Wrap and skip: rr_ptr=3, req_valid=4'b1001 -> grant 3, then 0; with req_valid=4'b0010 and rr_ptr=3 -> grant 1, then rr_ptr=2.
- Backpressure: stream from requester 1, then hold rsp_ready=0 for 5 cycles -> rsp_res/rsp_id stable; req_ready=0 after the 2nd accept. On release, the two pending results drain in order with no loss.
- Reset mid-flight: assert rst with both stages full -> next cycle rsp_valid=0, req_ready=0, rr_ptr=0. After deassert, req_valid=4'b1111 -> first grant is requester 0.
- Random stress: 10k cycles of random req_valid, operands and rsp_ready -> scoreboard matches every (id, product) in order against the per-requester accept queue; no lost or extra responses.
